vc_head_flit_queue: RTL
=======================

// Module: vc_head_flit_queue
// PURPOSE
//  Multi-VC successor of the single-plane head-flit buffer. Each VC keeps a queue of
//  HFB_DEPTH head flits, so back-to-back packets no longer stall. All VCs share one
//  external head-flit decoder through a round-robin arbiter. Each VC then holds a switch
//  route request until it is granted, and keeps the route reserved until the tail releases it.
//  Sits between the input-port FIFO/control FSM and the switch allocator.
// PARAMETERS
//  DATA_WIDTH     8  head flit width
//  VC             4  virtual channels (>=1)
//  HFB_DEPTH      4  head flits queued per VC (>=2)
//  REQUEST_WIDTH  2  encoded switch output request
//  localparam VCW = (VC>1)?$clog2(VC):1;  CW = $clog2(HFB_DEPTH+1)
// PORTS
//  clk              in   1              clock
//  rst              in   1              reset, synchronous, active-high
//  hf_push_valid    in   1              head flit arriving this cycle
//  hf_push_vc       in   VCW            target VC of arriving head flit
//  hf_push_flit     in   DATA_WIDTH     head flit
//  hf_full          out  VC             per-VC queue full
//  hf_empty         out  VC             per-VC queue empty
//  hf_overflow      out  1              1-cycle pulse: push to a full queue was discarded
//  dec_req_valid    out  1              decoder request valid
//  dec_req_ready    in   1              decoder accepts request
//  dec_req_vc       out  VCW            VC tag of request
//  dec_req_flit     out  DATA_WIDTH     head of the selected VC queue
//  dec_rsp_valid    in   1              decoder result valid (>=1 cycle after accept)
//  dec_rsp_vc       in   VCW            VC tag of result
//  dec_rsp_route    in   REQUEST_WIDTH  output-port request
//  dec_rsp_drop     in   1              packet is unroutable; drop it
//  route_req_valid  out  VC             per-VC switch request
//  route_req        out  VC*REQ_W       per-VC request, VC v at [v*REQ_W +: REQ_W]
//  route_grant      in   VC             switch grants VC route
//  route_release    in   VC             tail sent; free reserved route
//  route_held       out  VC             route reserved for this VC
//  drop_packet      out  VC             1-cycle pulse to control FSM: discard packet body
// BEHAVIOUR
//  Reset: all queues empty and all FSMs IDLE. Outputs after reset: hf_empty='1, hf_full=0,
//    dec_req_valid=0, route_req_valid=0, route_held=0, drop_packet=0, hf_overflow=0.
//  Queue: a push is accepted when count<HFB_DEPTH, or when the same VC pops in the same cycle.
//    Otherwise the push is discarded and hf_overflow pulses. The queue is a circular buffer
//    with wrapping pointers. The head is visible combinationally.
//  Per-VC FSM: IDLE -> DECODE when the queue is non-empty.
//    DECODE -> WAIT on a decoder handshake for this VC.
//    WAIT -> on dec_rsp_valid for this VC:
//      - drop=1: go to IDLE, pop, and pulse drop_packet the same cycle;
//      - otherwise latch the route and go to REQUEST.
//    REQUEST: route_req_valid=1 and route_req held stable.
//      route_grant -> HOLD; pop in the same cycle (Mealy).
//    HOLD: route_held=1. route_release -> IDLE.
//      If the queue is still non-empty, DECODE is entered the next cycle.
//  Arbiter: at most one decoder request is outstanding. A VC is eligible when in DECODE and
//    no request is outstanding. Eligible VCs are served round-robin; the pointer moves past
//    the winner on each handshake. dec_req_valid, vc and flit stay stable until ready.
//    No new request is issued until the outstanding response returns.
//    A response for a VC not in WAIT is ignored.
//  Stray inputs: route_grant outside REQUEST is ignored. route_release outside HOLD is ignored.
//  Simultaneous events: push and pop on the same VC keep count unchanged.
//    Grant and release on different VCs are independent.
//  Reset mid-operation: all state clears next edge and no pulse is emitted.
//    Outstanding decoder state is discarded.
// STRUCTURE
//  Package noc_hfq_pkg: typedef enum logic[2:0] hfq_state_e {IDLE, DECODE, WAIT, REQUEST,
//    HOLD}; function for VCW; request type typedef logic[REQUEST_WIDTH-1:0] route_req_t.
//  Sub-module hfq_lane, instantiated VC times in a generate loop. Each lane contains the
//    queue, the FSM and the route latch. The round-robin arbiter stays in the top module.
// TESTING
//  1. Push 3 flits to VC2; decoder route 2'b01 at 1-cycle latency; grant each.
//     -> three REQUEST/HOLD episodes with route_req[5:4]=01; hf_empty[2]=1 at end.
//  2. Fill VC0 with 4 flits, then push a 5th -> hf_overflow pulses once, hf_full[0]=1,
//     and queue contents are unchanged.
//  3. VC0, VC1 and VC3 enter DECODE together; ready=1 -> dec_req_vc order is 0,1,3,0...
//     and no request is issued while a response is pending.
//  4. Decoder answers drop=1 for VC1 -> drop_packet[1] is high for exactly 1 cycle,
//     count decrements by 1, and route_req_valid[1] never rises.
//  5. VC3 full with push to VC3 and grant on VC3 in the same cycle -> push accepted
//     and count stays 4.
//  6. Assert rst while VC0 is in HOLD and VC2 is in WAIT -> the next cycle has all
//     outputs at reset values and a late dec_rsp is ignored.

Source files
------------

// File: rtl/noc_hfq_pkg.sv
// Shared types and helpers for the multi-VC head-flit queue.
package noc_hfq_pkg;

    localparam int unsigned HFQ_REQ_W = 2;

    typedef logic [HFQ_REQ_W-1:0] route_req_t;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        REQUEST,
        HOLD
    } hfq_state_e;

    // Width of a VC index; a single VC still needs one bit.
    function automatic int unsigned vcWidth(input int unsigned vc);
        return (vc > 1) ? $clog2(vc) : 1;
    endfunction

endpackage

// File: rtl/hfq_lane.sv
// One VC lane: circular head-flit queue, decode/route FSM and route latch.
module hfq_lane
    import noc_hfq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned HFB_DEPTH     = 4,
    parameter int unsigned REQUEST_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pushEn,
    input  logic [DATA_WIDTH-1:0]    pushFlit,
    input  logic                     reqAccept,
    input  logic                     rspHit,
    input  logic                     rspDrop,
    input  logic [REQUEST_WIDTH-1:0] rspRoute,
    input  logic                     routeGrant,
    input  logic                     routeRelease,
    output logic [DATA_WIDTH-1:0]    headFlit,
    output logic                     isDecode,
    output logic                     isWait,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     routeReqValid,
    output logic [REQUEST_WIDTH-1:0] routeReq,
    output logic                     routeHeld,
    output logic                     dropPacket
);

    localparam int unsigned CW = $clog2(HFB_DEPTH + 1);
    localparam int unsigned PW = (HFB_DEPTH > 1) ? $clog2(HFB_DEPTH) : 1;

    logic [DATA_WIDTH-1:0]    mem [HFB_DEPTH];
    logic [PW-1:0]            wrPtr;
    logic [PW-1:0]            rdPtr;
    logic [CW-1:0]            count;
    hfq_state_e               state;
    logic [REQUEST_WIDTH-1:0] routeQ;
    logic                     rspTake;
    logic                     pop;
    logic                     pushOk;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == PW'(HFB_DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    // A drop response or a switch grant retires the head flit.
    assign rspTake = (state == WAIT) && rspHit;
    assign pop     = (rspTake && rspDrop) || ((state == REQUEST) && routeGrant);
    assign pushOk  = pushEn && ((count < CW'(HFB_DEPTH)) || pop);

    assign headFlit      = mem[rdPtr];
    assign full          = (count == CW'(HFB_DEPTH));
    assign empty         = (count == '0);
    assign isDecode      = (state == DECODE);
    assign isWait        = (state == WAIT);
    assign routeReqValid = (state == REQUEST);
    assign routeHeld     = (state == HOLD);
    assign routeReq      = routeQ;

    // Flit storage, no reset needed.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushFlit;
        end
    end

    // Queue pointers, occupancy and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= pushEn && !pushOk;
            if (pushOk) begin
                wrPtr <= incPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= incPtr(rdPtr);
            end
            if (pushOk && !pop) begin
                count <= CW'(count + 1'b1);
            end else if (!pushOk && pop) begin
                count <= CW'(count - 1'b1);
            end
        end
    end

    // Per-VC decode/request/hold sequencing with registered drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            routeQ     <= '0;
            dropPacket <= 1'b0;
        end else begin
            dropPacket <= rspTake && rspDrop;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (reqAccept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rspTake) begin
                        if (rspDrop) begin
                            state <= IDLE;
                        end else begin
                            routeQ <= rspRoute;
                            state  <= REQUEST;
                        end
                    end
                end
                REQUEST: begin
                    if (routeGrant) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (routeRelease) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vc_head_flit_queue.sv
// Multi-VC head-flit queue sharing one decoder through a round-robin arbiter.
module vc_head_flit_queue
    import noc_hfq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned VC            = 4,
    parameter int unsigned HFB_DEPTH     = 4,
    parameter int unsigned REQUEST_WIDTH = 2,
    localparam int unsigned VCW          = vcWidth(VC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hf_push_valid,
    input  logic [VCW-1:0]              hf_push_vc,
    input  logic [DATA_WIDTH-1:0]       hf_push_flit,
    output logic [VC-1:0]               hf_full,
    output logic [VC-1:0]               hf_empty,
    output logic                        hf_overflow,
    output logic                        dec_req_valid,
    input  logic                        dec_req_ready,
    output logic [VCW-1:0]              dec_req_vc,
    output logic [DATA_WIDTH-1:0]       dec_req_flit,
    input  logic                        dec_rsp_valid,
    input  logic [VCW-1:0]              dec_rsp_vc,
    input  logic [REQUEST_WIDTH-1:0]    dec_rsp_route,
    input  logic                        dec_rsp_drop,
    output logic [VC-1:0]               route_req_valid,
    output logic [VC*REQUEST_WIDTH-1:0] route_req,
    input  logic [VC-1:0]               route_grant,
    input  logic [VC-1:0]               route_release,
    output logic [VC-1:0]               route_held,
    output logic [VC-1:0]               drop_packet
);

    logic [DATA_WIDTH-1:0] heads [VC];
    logic [VC-1:0]         decodeVec;
    logic [VC-1:0]         waitVec;
    logic [VC-1:0]         overflowVec;
    logic                  reqValidQ;
    logic [VCW-1:0]        reqVcQ;
    logic                  pendQ;
    logic [VCW-1:0]        rrPtr;
    logic                  winFound;
    logic [VCW-1:0]        winVc;
    int unsigned           arbIdx;

    for (genvar v = 0; v < VC; v++) begin : gLane
        hfq_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .HFB_DEPTH    (HFB_DEPTH),
            .REQUEST_WIDTH(REQUEST_WIDTH)
        ) uLane (
            .clk          (clk),
            .rst          (rst),
            .pushEn       (hf_push_valid && (hf_push_vc == VCW'(v))),
            .pushFlit     (hf_push_flit),
            .reqAccept    (reqValidQ && dec_req_ready && (reqVcQ == VCW'(v))),
            .rspHit       (dec_rsp_valid && (dec_rsp_vc == VCW'(v))),
            .rspDrop      (dec_rsp_drop),
            .rspRoute     (dec_rsp_route),
            .routeGrant   (route_grant[v]),
            .routeRelease (route_release[v]),
            .headFlit     (heads[v]),
            .isDecode     (decodeVec[v]),
            .isWait       (waitVec[v]),
            .full         (hf_full[v]),
            .empty        (hf_empty[v]),
            .overflow     (overflowVec[v]),
            .routeReqValid(route_req_valid[v]),
            .routeReq     (route_req[v*REQUEST_WIDTH +: REQUEST_WIDTH]),
            .routeHeld    (route_held[v]),
            .dropPacket   (drop_packet[v])
        );
    end

    assign hf_overflow   = |overflowVec;
    assign dec_req_valid = reqValidQ;
    assign dec_req_vc    = reqVcQ;
    assign dec_req_flit  = heads[reqVcQ];

    // Round-robin pick of the first DECODE lane at or after the pointer.
    always_comb begin
        winFound = 1'b0;
        winVc    = '0;
        arbIdx   = 0;
        for (int unsigned i = 0; i < VC; i++) begin
            arbIdx = (int'(rrPtr) + i) % VC;
            if (!winFound && decodeVec[VCW'(arbIdx)]) begin
                winFound = 1'b1;
                winVc    = VCW'(arbIdx);
            end
        end
    end

    // Single outstanding decoder request: issue, hold until ready, wait for response.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqValidQ <= 1'b0;
            reqVcQ    <= '0;
            pendQ     <= 1'b0;
            rrPtr     <= '0;
        end else begin
            if (reqValidQ && dec_req_ready) begin
                reqValidQ <= 1'b0;
                pendQ     <= 1'b1;
                rrPtr     <= (reqVcQ == VCW'(VC - 1)) ? '0 : VCW'(reqVcQ + 1'b1);
            end else if (!reqValidQ && !pendQ && winFound) begin
                reqValidQ <= 1'b1;
                reqVcQ    <= winVc;
            end
            if (pendQ && dec_rsp_valid && waitVec[dec_rsp_vc]) begin
                pendQ <= 1'b0;
            end
        end
    end

endmodule
